// File: rtl/bp_perf_pkg.sv
// Shared types and elaboration helpers for the branch-prediction performance
// monitor.
//   state_e     : IDLE / COUNT run state
//   clog2_min1  : $clog2 that never returns less than 1 (for select/pointer widths)
//   win_w/sel_w : widths derived from WINDOW and NUM_CH
//   sat_inc     : increment that sticks at a caller-supplied ceiling
package bp_perf_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  function automatic int clog2_min1(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Window miss fields must be able to hold the value WINDOW itself.
  function automatic int win_w(input int window);
    return $clog2(window + 1);
  endfunction

  function automatic int sel_w(input int num_ch);
    return clog2_min1(num_ch);
  endfunction

  // Callers zero-extend into 64 bits and truncate the result back to their
  // own width, so one function serves every counter width up to 63 bits.
  function automatic logic [63:0] sat_inc(input logic [63:0] val,
                                          input logic [63:0] max_val);
    return (val >= max_val) ? val : val + 64'd1;
  endfunction

endpackage

// File: rtl/bp_perf_monitor_if.sv
// Window-record drain port of the performance monitor.
//   win_vld  : head record valid (monitor -> consumer)
//   win_rdy  : consumer accepts head (consumer -> monitor)
//   win_data : NUM_CH packed miss counts, channel 0 in the LSBs
//   win_ovf  : sticky flag, a record was dropped because the FIFO was full
// The monitor uses the master modport, the consumer the slave modport.
interface bp_perf_monitor_if
  import bp_perf_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WINDOW = 256
);
  localparam int WIN_W = win_w(WINDOW);

  logic                    win_vld;
  logic                    win_rdy;
  logic [NUM_CH*WIN_W-1:0] win_data;
  logic                    win_ovf;

  modport master (output win_vld, output win_data, output win_ovf, input win_rdy);
  modport slave  (input win_vld, input win_data, input win_ovf, output win_rdy);

endinterface

// File: rtl/bp_perf_fifo.sv
// Small synchronous FIFO holding closed window records.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : synchronous flush (pointers and occupancy to 0)
//   push/pop   : write / read strobes; pop on empty is ignored, push on full
//                is accepted only when a pop frees a slot in the same cycle
//   push_data  : record written on push
//   head_data  : oldest record, forced to 0 while empty
//   full/empty : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module bp_perf_fifo
  import bp_perf_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = clog2_min1(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             do_push;
  logic             do_pop;

  assign empty   = (occ == '0);
  assign full    = (occ == OCC_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage is never reset, so hide whatever it holds while nothing is queued.
  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr && !rst) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bp_perf_monitor.sv
// Branch-prediction performance monitor.
// Counts retired instructions plus per-channel branches and mispredictions for
// NUM_CH predictors in parallel, closes a window every WINDOW instructions and
// queues that window's per-channel miss counts for a valid/ready consumer.
//   clk_i, rst_i         : clock, synchronous active-high reset
//   start_i/stop_i       : enter / leave COUNT (both together: hold)
//   clear_i              : zero counters, window state, FIFO and overflow flag
//   instr_vld_i          : one instruction retired this cycle
//   br_instr_i/br_miss_i : per-channel branch retired / mispredicted
//   sel_i                : readback channel select (registered, 1-cycle latency)
//   instr_cnt_o          : cumulative retired instructions
//   br_cnt_o/miss_cnt_o  : cumulative branches / misses of the selected channel
//   active_o             : monitor is in COUNT
//   win_if               : window-record drain port (master side)
module bp_perf_monitor
  import bp_perf_pkg::*;
#(
  parameter int  NUM_CH     = 4,
  parameter int  CNT_W      = 32,
  parameter int  WINDOW     = 256,
  parameter int  HIST_DEPTH = 4,
  localparam int SEL_W      = sel_w(NUM_CH),
  localparam int WIN_W      = win_w(WINDOW)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic                     clear_i,
  input  logic                     instr_vld_i,
  input  logic [NUM_CH-1:0]        br_instr_i,
  input  logic [NUM_CH-1:0]        br_miss_i,
  input  logic [SEL_W-1:0]         sel_i,
  output logic [CNT_W-1:0]         instr_cnt_o,
  output logic [CNT_W-1:0]         br_cnt_o,
  output logic [CNT_W-1:0]         miss_cnt_o,
  output logic                     active_o,
  bp_perf_monitor_if.master        win_if
);

  localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;
  localparam logic [63:0] WIN_MAX = 64'(WINDOW);

  state_e                  state;
  logic                    cnt_en;
  logic                    win_close;
  logic                    win_pop;
  logic                    win_ovf;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    sel_ok;
  logic [WIN_W-1:0]        win_cnt;
  logic [NUM_CH*WIN_W-1:0] win_rec;
  logic [NUM_CH*WIN_W-1:0] fifo_head;
  logic [CNT_W-1:0]        br_cnt_arr   [NUM_CH];
  logic [CNT_W-1:0]        miss_cnt_arr [NUM_CH];

  // The stop_i cycle is still in COUNT and so still counts; the start_i cycle
  // is still in IDLE and does not.
  assign cnt_en    = (state == COUNT);
  assign active_o  = cnt_en;
  assign win_close = cnt_en && instr_vld_i && (win_cnt == WIN_W'(WINDOW - 1));
  assign win_pop   = !fifo_empty && win_if.win_rdy;
  assign sel_ok    = (int'(sel_i) < NUM_CH);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start_i && !stop_i) state <= COUNT;
        COUNT:   if (stop_i && !start_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      instr_cnt_o <= '0;
      win_cnt     <= '0;
    end else if (cnt_en && instr_vld_i) begin
      instr_cnt_o <= CNT_W'(sat_inc(64'(instr_cnt_o), CNT_MAX));
      win_cnt     <= win_close ? '0 : win_cnt + WIN_W'(1);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic             br_hit;
    logic             miss_hit;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] miss_cnt;
    logic [WIN_W-1:0] win_miss;
    logic [WIN_W-1:0] win_miss_nxt;

    assign br_hit   = cnt_en && br_instr_i[c];
    assign miss_hit = br_hit && br_miss_i[c];

    // Includes this cycle's miss so the closing instruction lands in its own
    // window's record.
    assign win_miss_nxt = miss_hit ? WIN_W'(sat_inc(64'(win_miss), WIN_MAX)) : win_miss;

    always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
        br_cnt   <= '0;
        miss_cnt <= '0;
        win_miss <= '0;
      end else begin
        if (br_hit)   br_cnt   <= CNT_W'(sat_inc(64'(br_cnt), CNT_MAX));
        if (miss_hit) miss_cnt <= CNT_W'(sat_inc(64'(miss_cnt), CNT_MAX));
        win_miss <= win_close ? '0 : win_miss_nxt;
      end
    end

    assign br_cnt_arr[c]                = br_cnt;
    assign miss_cnt_arr[c]              = miss_cnt;
    assign win_rec[c*WIN_W +: WIN_W]    = win_miss_nxt;
  end

  // Readback register stage: outputs reflect sel_i from the previous cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i || !sel_ok) begin
      br_cnt_o   <= '0;
      miss_cnt_o <= '0;
    end else begin
      br_cnt_o   <= br_cnt_arr[sel_i];
      miss_cnt_o <= miss_cnt_arr[sel_i];
    end
  end

  bp_perf_fifo #(
    .WIDTH (NUM_CH * WIN_W),
    .DEPTH (HIST_DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .clr       (clear_i),
    .push      (win_close),
    .push_data (win_rec),
    .pop       (win_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A same-cycle pop frees the slot, so a close on a full FIFO is only lost
  // when the consumer is not draining.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      win_ovf <= 1'b0;
    end else if (win_close && fifo_full && !win_pop) begin
      win_ovf <= 1'b1;
    end
  end

  assign win_if.win_vld  = !fifo_empty;
  assign win_if.win_data = fifo_head;
  assign win_if.win_ovf  = win_ovf;

endmodule

// File: tb/tb_bp_perf_monitor.sv
module tb_bp_perf_monitor;
  localparam int NUM_CH     = 4;
  localparam int CNT_W      = 4;
  localparam int WINDOW     = 8;
  localparam int HIST_DEPTH = 2;
  localparam int WIN_W      = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_i, start_i, stop_i, clear_i, instr_vld_i;
  logic [NUM_CH-1:0] br_instr_i, br_miss_i;
  logic [1:0]        sel_i;
  logic [CNT_W-1:0]  instr_cnt_o, br_cnt_o, miss_cnt_o;
  logic              active_o;

  bp_perf_monitor_if #(.NUM_CH(NUM_CH), .WINDOW(WINDOW)) win_if ();

  bp_perf_monitor #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .WINDOW(WINDOW), .HIST_DEPTH(HIST_DEPTH)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
    .clear_i(clear_i), .instr_vld_i(instr_vld_i), .br_instr_i(br_instr_i),
    .br_miss_i(br_miss_i), .sel_i(sel_i), .instr_cnt_o(instr_cnt_o),
    .br_cnt_o(br_cnt_o), .miss_cnt_o(miss_cnt_o), .active_o(active_o),
    .win_if(win_if)
  );

  typedef struct {
    logic       start, stop, vld;
    logic [3:0] br, miss;
    logic [1:0] sel;
    logic [3:0] e_instr, e_br, e_miss;
  } vec_t;

  vec_t vt[$];

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected window records in the order they must drain.
  logic [15:0] sb_q[$];
  bit          m_active;
  bit          m_ovf;
  int          m_win;
  int          m_wm [NUM_CH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, sp, v, input logic [3:0] br, ms,
                              input logic [1:0] sel, input int ei, eb, em);
    vec_t r;
    r.start = st; r.stop = sp; r.vld = v; r.br = br; r.miss = ms; r.sel = sel;
    r.e_instr = 4'(ei); r.e_br = 4'(eb); r.e_miss = 4'(em);
    return r;
  endfunction

  task automatic drive(input logic st, sp, cl, v, input logic [3:0] br, ms);
    start_i = st; stop_i = sp; clear_i = cl; instr_vld_i = v;
    br_instr_i = br; br_miss_i = ms;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
  endtask

  // One clock: compare any record the DUT hands over, advance the model with
  // the inputs currently applied, then check the flags #1 after the edge.
  task automatic tick();
    logic [15:0] rec;
    if (win_if.win_vld && win_if.win_rdy) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_pop actual=%0h expected=no_record", win_if.win_data);
      end else begin
        chk("sb_pop", 64'(win_if.win_data), 64'(sb_q.pop_front()));
      end
    end
    if (rst_i) begin
      sb_q.delete(); m_ovf = 0; m_win = 0; m_active = 0;
      foreach (m_wm[c]) m_wm[c] = 0;
    end else begin
      if (clear_i) begin
        sb_q.delete(); m_ovf = 0; m_win = 0;
        foreach (m_wm[c]) m_wm[c] = 0;
      end else if (m_active) begin
        for (int c = 0; c < NUM_CH; c++)
          if (br_instr_i[c] && br_miss_i[c] && m_wm[c] < WINDOW) m_wm[c]++;
        if (instr_vld_i) begin
          if (m_win == WINDOW - 1) begin
            rec = '0;
            for (int c = 0; c < NUM_CH; c++) rec[c*WIN_W +: WIN_W] = WIN_W'(m_wm[c]);
            if (sb_q.size() < HIST_DEPTH) sb_q.push_back(rec);
            else m_ovf = 1;
            m_win = 0;
            foreach (m_wm[c]) m_wm[c] = 0;
          end else begin
            m_win++;
          end
        end
      end
      if (!m_active && start_i && !stop_i) m_active = 1;
      else if (m_active && stop_i && !start_i) m_active = 0;
    end
    @(posedge clk);
    #1;
    chk("win_vld", 64'(win_if.win_vld), 64'(sb_q.size() != 0));
    chk("win_ovf", 64'(win_if.win_ovf), 64'(m_ovf));
    chk("active", 64'(active_o), 64'(m_active));
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      sel_i = vt[i].sel;
      drive(vt[i].start, vt[i].stop, 1'b0, vt[i].vld, vt[i].br, vt[i].miss);
      tick();
      chk($sformatf("vec%0d_instr", i), 64'(instr_cnt_o), 64'(vt[i].e_instr));
      chk($sformatf("vec%0d_br", i), 64'(br_cnt_o), 64'(vt[i].e_br));
      chk($sformatf("vec%0d_miss", i), 64'(miss_cnt_o), 64'(vt[i].e_miss));
    end
  endtask

  task automatic chk_counts_zero(input string tag);
    chk({tag, "_instr"}, 64'(instr_cnt_o), 64'd0);
    chk({tag, "_br"}, 64'(br_cnt_o), 64'd0);
    chk({tag, "_miss"}, 64'(miss_cnt_o), 64'd0);
    chk({tag, "_data"}, 64'(win_if.win_data), 64'd0);
  endtask

  initial begin
    // Rows 0..12: basic counting, start cycle ignored, readback select.
    vt.push_back(mk(1, 0, 1, 4'b0011, 4'b0001, 0, 0, 0, 0));
    for (int k = 1; k <= 10; k++) vt.push_back(mk(0, 0, 1, 4'b0011, 4'b0001, 0, k, k-1, k-1));
    vt.push_back(mk(0, 0, 0, 4'h0, 4'h0, 0, 10, 10, 10));
    vt.push_back(mk(0, 0, 0, 4'h0, 4'h0, 1, 10, 10, 0));
    // Rows 13..26: unqualified misses, start+stop hold, stop cycle counted, paused.
    for (int k = 0; k < 5; k++) vt.push_back(mk(0, 0, 0, 4'h0, 4'hF, 0, 0, 0, 0));
    vt.push_back(mk(1, 1, 0, 4'h0, 4'h0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 4'h0, 4'h0, 2, 0, 0, 0));
    vt.push_back(mk(0, 1, 0, 4'b0001, 4'b0001, 0, 0, 0, 0));
    for (int k = 0; k < 5; k++) vt.push_back(mk(0, 0, 0, 4'hF, 4'hF, 0, 0, 1, 1));
    vt.push_back(mk(0, 0, 0, 4'h0, 4'h0, 1, 0, 0, 0));

    rst_i = 1; sel_i = 0; win_if.win_rdy = 0; idle();
    tick(); tick();
    chk_counts_zero("reset");
    rst_i = 0;

    // Counting and readback.
    win_if.win_rdy = 1;
    run_vecs(0, 12);

    // One window, channel 2 misses on 3 of 8 including the closing one.
    win_if.win_rdy = 0;
    drive(0, 0, 1, 0, 4'h0, 4'h0); tick();
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 1, 4'b0100, (i == 1 || i == 4 || i == 7) ? 4'b0100 : 4'b0000);
      tick();
    end
    chk("win_vld_after_close", 64'(win_if.win_vld), 64'd1);
    chk("win_data_ch2", 64'(win_if.win_data), 64'h0300);
    idle(); win_if.win_rdy = 1; tick();

    // Three windows into a 2-deep FIFO with no drain: third dropped.
    win_if.win_rdy = 0;
    drive(0, 0, 1, 0, 4'h0, 4'h0); tick();
    for (int w = 0; w < 3; w++)
      for (int i = 0; i < 8; i++) begin
        drive(0, 0, 0, 1, 4'hF,
              (w == 0) ? ((i < 1) ? 4'b0001 : 4'b0000) :
              (w == 1) ? ((i < 2) ? 4'b0010 : 4'b0000) :
                         ((i < 5) ? 4'b1000 : 4'b0000));
        tick();
      end
    chk("ovf_after_drop", 64'(win_if.win_ovf), 64'd1);
    chk("head_first", 64'(win_if.win_data), 64'h0001);
    idle(); win_if.win_rdy = 1; tick();
    chk("head_second", 64'(win_if.win_data), 64'h0020);
    tick();
    win_if.win_rdy = 0;

    // Full FIFO, close coincides with a pop: accepted, no overflow.
    drive(0, 0, 1, 0, 4'h0, 4'h0); tick();
    for (int w = 0; w < 3; w++)
      for (int i = 0; i < 8; i++) begin
        if (w == 2 && i == 7) win_if.win_rdy = 1;
        drive(0, 0, 0, 1, 4'b0100, (i <= w) ? 4'b0100 : 4'b0000);
        tick();
      end
    chk("full_pushpop_ovf", 64'(win_if.win_ovf), 64'd0);
    chk("full_pushpop_head", 64'(win_if.win_data), 64'h0200);
    idle(); tick(); tick();

    // Saturation of a 4-bit branch counter.
    drive(0, 0, 1, 0, 4'h0, 4'h0); tick();
    for (int i = 0; i < 20; i++) begin drive(0, 0, 0, 0, 4'b0001, 4'h0); tick(); end
    sel_i = 0; idle(); tick();
    chk("sat_br", 64'(br_cnt_o), 64'd15);
    chk("sat_miss", 64'(miss_cnt_o), 64'd0);
    chk("sat_instr", 64'(instr_cnt_o), 64'd0);

    // Miss qualification and pause.
    drive(0, 0, 1, 0, 4'h0, 4'h0); tick();
    run_vecs(13, 26);

    // Clear on the closing cycle with one record queued.
    win_if.win_rdy = 0; sel_i = 0;
    drive(1, 0, 0, 0, 4'h0, 4'h0); tick();
    drive(0, 0, 1, 0, 4'h0, 4'h0); tick();
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        chk("preclr_vld", 64'(win_if.win_vld), 64'd1);
        chk("preclr_br", 64'(br_cnt_o), 64'd14);
      end
      drive(0, 0, (i == 15), 1, 4'b0001, 4'b0001);
      tick();
    end
    chk_counts_zero("clr_close");
    chk("clr_active", 64'(active_o), 64'd1);
    idle(); tick();
    chk_counts_zero("clr_after");

    // Reset mid-window with a record queued.
    for (int i = 0; i < 11; i++) begin drive(0, 0, 0, 1, 4'b0001, 4'b0001); tick(); end
    chk("prerst_vld", 64'(win_if.win_vld), 64'd1);
    idle(); rst_i = 1; tick();
    chk_counts_zero("mid_reset");
    rst_i = 0; tick();
    chk("rst_idle", 64'(active_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_perf_monitor.md
Name: bp_perf_monitor

Overview:
Parametrised branch-prediction performance monitor for the pipelined core bench.
- Counts retired instructions, branch/jump instructions and mispredictions on NUM_CH predictor channels at once, e.g. always-taken, two-bit, gshare and agree running side by side.
- Closes a fixed instruction window and pushes that window's per-channel miss counts into a small FIFO with a valid/ready drain port.
- Cumulative counters are read back through a registered channel-select port.

Parameters:
NUM_CH, 4, number of predictor channels monitored in parallel (>=1)
CNT_W, 32, width of cumulative counters; all saturate at 2^CNT_W-1
WINDOW, 256, retired instructions per statistics window (>=2)
HIST_DEPTH, 4, window-record FIFO depth (power of two, >=2)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  reset, synchronous, active-high
start_i  in  1  pulse: begin/resume counting
stop_i  in  1  pulse: pause counting
clear_i  in  1  pulse: zero all counters, window state, FIFO and overflow flag
instr_vld_i  in  1  one retired instruction this cycle
br_instr_i  in  NUM_CH  channel c retired a branch/jump this cycle
br_miss_i  in  NUM_CH  channel c mispredicted that branch
sel_i  in  SEL_W=max(1,$clog2(NUM_CH))  channel select for readback
instr_cnt_o  out  CNT_W  cumulative retired instructions
br_cnt_o  out  CNT_W  cumulative branches of channel sel_i
miss_cnt_o  out  CNT_W  cumulative misses of channel sel_i
active_o  out  1  state==COUNT
win_vld_o  out  1  FIFO head valid
win_rdy_i  in  1  consumer accepts head
win_data_o  out  NUM_CH*WIN_W  per-channel window miss counts, channel 0 in LSBs; WIN_W=$clog2(WINDOW+1)
win_ovf_o  out  1  sticky: a window record was dropped

Behaviour:
- Reset:
  - state IDLE.
  - All counters, window counter, FIFO pointers and occupancy 0.
  - All outputs 0: active_o, win_vld_o, win_data_o, win_ovf_o, instr_cnt_o, br_cnt_o, miss_cnt_o.
- FSM states IDLE and COUNT:
  - IDLE->COUNT on start_i.
  - COUNT->IDLE on stop_i.
  - start_i and stop_i together: hold current state.
  - clear_i does not change state.
- Counting happens only in COUNT, including the cycle in which stop_i is sampled. Inputs in the start_i cycle are not counted.
- Qualification:
  - br_miss_i[c] counts only when br_instr_i[c]=1. A miss without a branch is ignored.
  - Branch inputs count independently of instr_vld_i.
- Cumulative counters increment by 1 per qualifying cycle and saturate with no wrap.
- Window:
  - The window counter increments on instr_vld_i.
  - Per-channel window miss counters are WIN_W wide and saturate at WINDOW.
  - When the window counter == WINDOW-1 and instr_vld_i=1, the window closes. The record includes a miss sampled in that closing cycle.
  - On close: push the record, reset the window counter and window miss counters to 0 next cycle.
- FIFO:
  - Push on close if not full.
  - If full, drop the record and set win_ovf_o; it is cleared only by clear_i or reset.
  - Pop when win_vld_o && win_rdy_i.
  - Push and pop in the same cycle when full: pop frees a slot, push accepted, no overflow.
  - Data is stable while win_vld_o=1 and not popped.
  - Push-to-win_vld_o latency is 1 cycle.
- Readback:
  - br_cnt_o and miss_cnt_o are registered, 1-cycle latency from sel_i.
  - sel_i >= NUM_CH returns 0.
  - instr_cnt_o is the register itself.
- clear_i has priority over all same-cycle increments and pushes: the next cycle shows all zeros, win_vld_o=0 and win_ovf_o=0.
- Reset mid-window or with the FIFO non-empty discards everything.

Decomposition:
- Package bp_perf_pkg holds:
  - state_e {IDLE, COUNT}
  - function clog2_min1
  - localparams WIN_W and SEL_W helper functions
  - a saturating-increment function
- One sub-module: bp_perf_fifo, a synchronous FIFO with parametrised width/depth and full/empty.
- Per-channel counters are a generate loop, not separate modules.

Test Plan:
1. Reset then start_i, 10 instr_vld_i with br_instr_i=4'b0011 and br_miss_i=4'b0001 each cycle, sel_i=0 -> instr_cnt_o=10, br_cnt_o=10, miss_cnt_o=10. With sel_i=1 -> br_cnt_o=10, miss_cnt_o=0 one cycle later.
2. WINDOW=8, channel 2 misses on 3 of 8 instructions, including the closing one -> win_vld_o=1 one cycle after close, win_data_o field 2 = 3, all others 0.
3. HIST_DEPTH=2, win_rdy_i=0, run 3 windows -> 2 records held, third dropped, win_ovf_o=1. Then pop twice -> the first two records appear in order.
4. CNT_W=4, 20 branches on channel 0 -> br_cnt_o saturates at 15.
5. br_miss_i=1 with br_instr_i=0 for 5 cycles -> miss_cnt_o stays 0. stop_i then 5 branches -> counts unchanged, active_o=0.
6. clear_i asserted in the same cycle as a window close with the FIFO holding one record -> next cycle all counters 0, win_vld_o=0, win_ovf_o=0, state unchanged (COUNT).
